// File: rtl/i2c_fifo_pkg.sv
// Shared types, defaults and helpers for the I2C TX FIFO.
//   i2c_tx_entry_t : one TX entry, cmd (1 = read, 0 = write) plus data byte
//   eff_tl()       : clamps the TX_EMPTY threshold to DEPTH-1
package i2c_fifo_pkg;

    localparam int unsigned I2C_TX_DEPTH_DEF = 8;
    localparam int unsigned I2C_TX_DW        = 9;

    typedef struct packed {
        logic       cmd;
        logic [7:0] data;
    } i2c_tx_entry_t;

    function automatic int unsigned eff_tl(input logic [7:0] tl, input int unsigned depth);
        int unsigned t;
        t = 32'(tl);
        return (t < depth - 1) ? t : depth - 1;
    endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// DEPTH x DW storage for the I2C TX FIFO; not reset.
// Ports:
//   clk          clock
//   we/waddr/wdata  synchronous write port
//   raddr/rdata     asynchronous read port
module i2c_fifo_mem
    import i2c_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = I2C_TX_DEPTH_DEF,
    parameter int unsigned DW    = I2C_TX_DW,
    parameter int unsigned ADDR  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [ADDR-1:0] waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [ADDR-1:0] raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_tx_fifo_ctrl.sv
// I2C transmit command/data FIFO controller (first-word-fall-through).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tx_push, tx_push_data    push strobe and entry from the register file
//   tx_pop, tx_pop_data      pop strobe from the bit engine, head entry (0 when empty)
//   flush                    discard all entries; tx_over is kept
//   tx_tl                    TX_EMPTY threshold
//   clr_tx_over              clear sticky overflow
//   tx_level, tx_full, tx_empty, tx_empty_intr, tx_over   status
// Optional (macro I2C_TX_FIFO_WATERMARK_EN):
//   clr_watermark, tx_max_level   high-water mark of tx_level
module i2c_tx_fifo_ctrl
    import i2c_fifo_pkg::*;
#(
    parameter int unsigned  DEPTH = I2C_TX_DEPTH_DEF,
    parameter int unsigned  DW    = I2C_TX_DW,
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_push,
    input  logic [DW-1:0] tx_push_data,
    input  logic          tx_pop,
    output logic [DW-1:0] tx_pop_data,
    input  logic          flush,
    input  logic [7:0]    tx_tl,
    input  logic          clr_tx_over,
    output logic [LW-1:0] tx_level,
    output logic          tx_full,
    output logic          tx_empty,
    output logic          tx_empty_intr,
    output logic          tx_over
`ifdef I2C_TX_FIFO_WATERMARK_EN
    ,
    input  logic          clr_watermark,
    output logic [LW-1:0] tx_max_level
`endif
);

    localparam int unsigned ADDR = $clog2(DEPTH);

    logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            over_q, over_d;
    logic            push_ok, pop_ok, over_set;
    logic            mem_we;
    logic [DW-1:0]   head;

    assign tx_full  = (level_q == LW'(DEPTH));
    assign tx_empty = (level_q == '0);

    always_comb begin
        // A pop in the same cycle frees the slot, so a push while full still goes in.
        push_ok  = tx_push && (!tx_full || tx_pop);
        pop_ok   = tx_pop && !tx_empty;
        over_set = tx_push && tx_full && !tx_pop;
        mem_we   = push_ok && !flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + ADDR'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR'(1);
            if (push_ok && !pop_ok) begin
                level_d = level_q + LW'(1);
            end else if (pop_ok && !push_ok) begin
                level_d = level_q - LW'(1);
            end
        end

        // Set beats clear; flush leaves the flag alone.
        over_d = over_q;
        if (over_set) begin
            over_d = 1'b1;
        end else if (clr_tx_over) begin
            over_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            over_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            over_q   <= over_d;
        end
    end

    i2c_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .ADDR  (ADDR)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (tx_push_data),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign tx_pop_data   = tx_empty ? '0 : head;
    assign tx_level      = level_q;
    assign tx_over       = over_q;
    assign tx_empty_intr = (32'(level_q) <= eff_tl(tx_tl, DEPTH));

`ifdef I2C_TX_FIFO_WATERMARK_EN
    logic [LW-1:0] max_q;

    // Track the next-state level so the mark never lags the level output.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
        end else if (clr_watermark) begin
            max_q <= level_q;
        end else if (level_d > max_q) begin
            max_q <= level_d;
        end
    end

    assign tx_max_level = max_q;
`endif

endmodule

// File: tb/tb_i2c_tx_fifo_ctrl.sv
// Self-checking bench for i2c_tx_fifo_ctrl: queue-based reference model checked every
// cycle, plus directed literal expectations.
module tb_i2c_tx_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 9;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_push = 1'b0;
    logic [DW-1:0] tx_push_data = '0;
    logic          tx_pop = 1'b0;
    logic [DW-1:0] tx_pop_data;
    logic          flush = 1'b0;
    logic [7:0]    tx_tl = 8'd0;
    logic          clr_tx_over = 1'b0;
    logic [LW-1:0] tx_level;
    logic          tx_full, tx_empty, tx_empty_intr, tx_over;
`ifdef I2C_TX_FIFO_WATERMARK_EN
    logic          clr_watermark = 1'b0;
    logic [LW-1:0] tx_max_level;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    i2c_tx_fifo_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .tx_push       (tx_push),
        .tx_push_data  (tx_push_data),
        .tx_pop        (tx_pop),
        .tx_pop_data   (tx_pop_data),
        .flush         (flush),
        .tx_tl         (tx_tl),
        .clr_tx_over   (clr_tx_over),
        .tx_level      (tx_level),
        .tx_full       (tx_full),
        .tx_empty      (tx_empty),
        .tx_empty_intr (tx_empty_intr),
        .tx_over       (tx_over)
`ifdef I2C_TX_FIFO_WATERMARK_EN
        ,
        .clr_watermark (clr_watermark),
        .tx_max_level  (tx_max_level)
`endif
    );

    // Reference model: the FIFO contents as a queue plus the sticky flag.
    logic [DW-1:0] q[$];
    bit            m_over = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_over = 1'b0;
        end else begin
            if (tx_push && q.size() == DEPTH && !tx_pop) m_over = 1'b1;
            else if (clr_tx_over) m_over = 1'b0;
            if (flush) begin
                q.delete();
            end else begin
                bit do_pop, do_push;
                do_pop  = tx_pop && q.size() > 0;
                do_push = tx_push && (q.size() < DEPTH || tx_pop);
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(tx_push_data);
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            int lvl, eff;
            lvl = q.size();
            eff = (int'(tx_tl) < DEPTH - 1) ? int'(tx_tl) : DEPTH - 1;
            chk("model level", int'(tx_level), lvl);
            chk("model full", int'(tx_full), int'(lvl == DEPTH));
            chk("model empty", int'(tx_empty), int'(lvl == 0));
            chk("model intr", int'(tx_empty_intr), int'(lvl <= eff));
            chk("model over", int'(tx_over), int'(m_over));
            chk("model head", int'(tx_pop_data), (lvl > 0) ? int'(q[0]) : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst level", int'(tx_level), 0);
        chk("rst empty", int'(tx_empty), 1);
        chk("rst full", int'(tx_full), 0);
        chk("rst intr", int'(tx_empty_intr), 1);
        chk("rst over", int'(tx_over), 0);
        chk("rst head", int'(tx_pop_data), 0);

        // Held push of 0A5 for three cycles
        tx_push = 1'b1; tx_push_data = 9'h0A5;
        repeat (3) cyc();
        tx_push = 1'b0;
        @(negedge clk);
        chk("hold3 level", int'(tx_level), 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold3 pop", int'(tx_pop_data), 'h0A5);
            tx_pop = 1'b1;
            cyc();
            tx_pop = 1'b0;
        end
        @(negedge clk);
        chk("hold3 empty", int'(tx_empty), 1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            tx_push = 1'b1; tx_push_data = DW'(9'h100 + i);
            cyc();
        end
        tx_push_data = 9'h1FF;
        cyc();
        tx_push = 1'b0;
        @(negedge clk);
        chk("ovf full", int'(tx_full), 1);
        chk("ovf over", int'(tx_over), 1);
        chk("ovf level", int'(tx_level), 8);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("ovf pop order", int'(tx_pop_data), 'h100 + i);
            tx_pop = 1'b1;
            cyc();
            tx_pop = 1'b0;
        end
        @(negedge clk);
        chk("ovf drained", int'(tx_empty), 1);
        chk("ovf head zero", int'(tx_pop_data), 0);
        clr_tx_over = 1'b1;
        cyc();
        clr_tx_over = 1'b0;
        @(negedge clk);
        chk("clr over", int'(tx_over), 0);

        // Push+pop while full
        for (int i = 0; i < 8; i++) begin
            tx_push = 1'b1; tx_push_data = DW'(9'h010 + i);
            cyc();
        end
        tx_pop = 1'b1; tx_push_data = 9'h0EE;
        cyc();
        tx_push = 1'b0; tx_pop = 1'b0;
        @(negedge clk);
        chk("pp level", int'(tx_level), 8);
        chk("pp over", int'(tx_over), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("pp order", int'(tx_pop_data), (i < 7) ? ('h011 + i) : 'h0EE);
            tx_pop = 1'b1;
            cyc();
            tx_pop = 1'b0;
        end

        // Threshold: TL=2 for levels 0..3, then TL=200 (clamped to 7) for 4..8
        tx_tl = 8'd2;
        for (int lvl = 0; lvl <= 8; lvl++) begin
            if (lvl == 4) tx_tl = 8'd200;
            @(negedge clk);
            chk("thr intr", int'(tx_empty_intr), (lvl <= ((lvl < 4) ? 2 : 7)) ? 1 : 0);
            if (lvl < 8) begin
                tx_push = 1'b1; tx_push_data = DW'(9'h040 + lvl);
                cyc();
                tx_push = 1'b0;
            end
        end

        // Overflow to set tx_over, flush, queue 5, then flush with push and pop
        tx_push = 1'b1; tx_push_data = 9'h055;
        cyc();
        tx_push = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_push = 1'b1; tx_push_data = DW'(9'h030 + i);
            cyc();
        end
        tx_push_data = 9'h077; tx_pop = 1'b1; flush = 1'b1;
        cyc();
        tx_push = 1'b0; tx_pop = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush level", int'(tx_level), 0);
        chk("flush empty", int'(tx_empty), 1);
        chk("flush head", int'(tx_pop_data), 0);
        chk("flush over kept", int'(tx_over), 1);

        // FIFO still works after flush
        tx_push = 1'b1; tx_push_data = 9'h1AB;
        cyc();
        tx_push = 1'b0; clr_tx_over = 1'b1;
        cyc();
        clr_tx_over = 1'b0;
        @(negedge clk);
        chk("post flush head", int'(tx_pop_data), 'h1AB);
        chk("post flush level", int'(tx_level), 1);
        chk("post clr over", int'(tx_over), 0);

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_tx_fifo_ctrl.md
Name: i2c_tx_fifo_ctrl

Overview:
- Transmit command/data FIFO directly downstream of the I2C register file.
- Absorbs tx_push/tx_push_data (command bit plus data byte, written via IC_DATA_CMD) and presents the head entry to the master/slave bit engine, which pops it.
- Produces TX level, full/empty, TX_EMPTY threshold status and the sticky TX_OVER flag back to the register file.

Parameters:
- DEPTH, 8, number of 9-bit entries; power of two, 2..256.
- DW, 9, entry width: bit 8 = cmd (1 = read, 0 = write), bits 7:0 = data.
- LW, $clog2(DEPTH+1), width of the level output; derived, not overridden.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- tx_push  in  1  push strobe; one entry is pushed per cycle it is high.
- tx_push_data  in  DW  entry to push.
- tx_pop  in  1  pop strobe from the bit engine, one entry per cycle.
- tx_pop_data  out  DW  head entry (first-word-fall-through).
- flush  in  1  discard all entries (abort / IC_ENABLE=0).
- tx_tl  in  8  TX_EMPTY threshold (IC_TX_TL).
- clr_tx_over  in  1  clear the sticky overflow flag.
- tx_level  out  LW  current entry count.
- tx_full  out  1  level == DEPTH.
- tx_empty  out  1  level == 0.
- tx_empty_intr  out  1  level <= effective threshold.
- tx_over  out  1  sticky: a push was attempted while full.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset values: write pointer, read pointer and level = 0; tx_empty=1; tx_full=0; tx_over=0; tx_empty_intr=1; tx_pop_data=0. The storage array is not reset.
- Push accepted when tx_push && (!tx_full || tx_pop).
  - Entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop accepted when tx_pop && !tx_empty.
  - rd_ptr increments modulo DEPTH.
  - A pop while empty is ignored and has no other effect.
- Latency: an entry pushed in cycle N is visible on tx_pop_data, and reflected in tx_level, from cycle N+1. There is no same-cycle fall-through when empty.
- tx_pop_data = mem[rd_ptr] when !tx_empty, else 0.
- Simultaneous push and pop:
  - Not empty: both accepted; level unchanged.
  - Full: both accepted; no overflow.
  - Empty: push only; level becomes 1.
- Overflow: tx_push && tx_full && !tx_pop drops the entry and sets tx_over. Pointers and level are unchanged.
- tx_over is cleared by clr_tx_over. If a set and a clear occur in the same cycle, set wins.
- flush has top priority:
  - Pointers and level go to 0 next cycle; any push or pop in the same cycle is discarded.
  - tx_over is unaffected by flush.
- Threshold: effective TL = min(tx_tl, DEPTH-1). tx_empty_intr = (tx_level <= effective TL), decoded from the registered level.
- Arithmetic: level updates as +1, -1 or 0 per cycle and never leaves the range 0..DEPTH. Pointers are ADDR=$clog2(DEPTH) bits wide and wrap naturally.
- tx_push is a per-cycle strobe. Holding it for k cycles pushes k copies, saturating at full; further copies while full set tx_over.

Optional Feature:
- Macro: I2C_TX_FIFO_WATERMARK_EN.
- When defined:
  - Adds output tx_max_level [LW-1:0], the highest tx_level reached since reset or the last clear.
  - Adds input clr_watermark, which loads tx_max_level with the current tx_level.
  - flush does not clear tx_max_level.
- When undefined: neither port exists, and there is no watermark logic.

Decomposition:
- Package i2c_fifo_pkg:
  - typedef i2c_tx_entry_t packed struct {logic cmd; logic [7:0] data;}.
  - Constants I2C_TX_DEPTH_DEF=8 and I2C_TX_DW=9.
  - Function eff_tl(tl, depth) returning min(tl, depth-1).
- Sub-module i2c_fifo_mem: DEPTH x DW array, one synchronous write port, one asynchronous read port. The controller holds pointers, level, flags and interrupt.

Test Plan:
- Reset, then idle: tx_level=0, tx_empty=1, tx_empty_intr=1, tx_over=0, tx_pop_data=9'h000.
- tx_push held 3 cycles with 9'h0A5 -> tx_level=3 from the cycle after the last push; three pops return 9'h0A5 each; tx_empty=1 afterwards.
- Push 8 entries 9'h100..9'h107, then a 9th push 9'h1FF -> tx_full=1, tx_over=1, pops return 9'h100..9'h107 in order, 9'h1FF is never seen; clr_tx_over -> tx_over=0.
- Full FIFO with push+pop in the same cycle -> level stays 8, tx_over stays 0, new entry appears last.
- tx_tl=2: levels 0..2 -> intr=1, level 3 -> 0; tx_tl=200 -> effective TL 7, intr=0 only at level 8.
- 5 entries queued, flush asserted together with push and pop -> next cycle level=0, tx_empty=1, tx_pop_data=0, tx_over unchanged.
